// File: rtl/sr_bank_if.sv
// Bus between sr_bank_driver and its command source / SR flop bank.
//
// Handshake: a target transfers on every rising clk edge where tgt_valid and
// tgt_ready are both high. tgt_data must be stable while tgt_valid is high.
// tgt_data is ignored while tgt_valid is low. The source may hold tgt_valid
// high across cycles. tgt_ready is the only backpressure.
interface sr_bank_if #(
  parameter int WIDTH = 8
);
  logic                 tgt_valid;
  logic                 tgt_ready;
  logic [WIDTH-1:0]     tgt_data;
  logic [2*WIDTH-1:0]   sr_out;
  logic [WIDTH-1:0]     q_in;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [2:0]           retry_cnt;

  // Command source plus flop bank side.
  modport master (
    output tgt_valid, tgt_data, q_in,
    input  tgt_ready, sr_out, busy, done, err, retry_cnt
  );

  // The bank driver itself.
  modport slave (
    input  tgt_valid, tgt_data, q_in,
    output tgt_ready, sr_out, busy, done, err, retry_cnt
  );
endinterface

// File: rtl/sr_bank_driver.sv
// sr_bank_driver: writes a target pattern into a bank of WIDTH SR flops.
// It drives {s,r} codes per bit, waits SETTLE idle cycles, reads q back and
// retries up to MAX_RETRY times before reporting done or err.
// Code 11 is never produced.
// Optional macro SR_FORCE_WRITE_EN: drive every bit on each DRIVE cycle,
// including bits that already match, instead of only the mismatching ones.
module sr_bank_driver #(
  parameter int WIDTH     = 8,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst,
  sr_bank_if.slave   bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SETTLE = 2'd2,
    S_CHECK  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     tgt_q, tgt_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           retry_q, retry_d;
  logic [2*WIDTH-1:0]   sr_q, sr_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [WIDTH-1:0]     code_tgt;
  logic [WIDTH-1:0]     drive_mask;
  logic [2*WIDTH-1:0]   drive_codes;

  // Precompute the DRIVE-cycle codes one cycle early because sr_out is
  // registered. The bank is held (sr=00) in the cycle before DRIVE, so
  // q_in is the same value the flops will hold during DRIVE.
  always_comb begin
    code_tgt = (state_q == S_IDLE) ? bus.tgt_data : tgt_q;
`ifdef SR_FORCE_WRITE_EN
    drive_mask = '1;
`else
    drive_mask = bus.q_in ^ code_tgt;
`endif
    drive_codes = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (drive_mask[i]) begin
        drive_codes[2*i +: 2] = code_tgt[i] ? 2'b10 : 2'b01;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    sr_d    = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.tgt_valid && ready_q) begin
          tgt_d   = bus.tgt_data;
          retry_d = 3'd0;
          sr_d    = drive_codes;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        cnt_d   = 4'(SETTLE - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CHECK: begin
        // An unknown readback bit makes this compare non-true, so it
        // falls into the mismatch path.
        if ((bus.q_in ^ tgt_q) == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (retry_q < 3'(MAX_RETRY)) begin
          retry_d = retry_q + 3'd1;
          sr_d    = drive_codes;
          state_d = S_DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
      retry_q <= '0;
      sr_q    <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      sr_q    <= sr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.sr_out    = sr_q;
  assign bus.tgt_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.retry_cnt = retry_q;
  assign dbg_state     = state_q;

endmodule
